// File: rtl/noc_pkg.sv
// Shared NoC switch definitions: port direction encoding and the index-width helper
// used to size direction/owner fields.
package noc_pkg;

   localparam int DIR_NORTH = 0;
   localparam int DIR_SOUTH = 1;
   localparam int DIR_WEST  = 2;
   localparam int DIR_EAST  = 3;

   function automatic int req_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit found scanning upward
// from ptr, wrapping modulo N.
module rr_arbiter
   import noc_pkg::*;
#(
   parameter int N = 4,
   parameter int W = req_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_any
);

   int idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = W'(idx);
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_route_arbiter.sv
// Route allocator: grants each free switch output to one input by per-output
// round-robin and holds the grant until the owning input relieves it.
module switch_route_arbiter
   import noc_pkg::*;
#(
   parameter int N             = 4,
   parameter int REQUEST_WIDTH = req_width(N)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0]               req_valid,
   input  logic [N*REQUEST_WIDTH-1:0] req_dir,
   input  logic [N-1:0]               relieve,
   output logic [N-1:0]               grant_status,
   output logic [N-1:0]               out_busy,
   output logic [N*REQUEST_WIDTH-1:0] out_sel
);

   localparam int W = REQUEST_WIDTH;

   logic [N-1:0] busy_q, busy_d;
   logic [N-1:0] grant_q, grant_d;
   logic [W-1:0] owner_q [N];
   logic [W-1:0] owner_d [N];
   logic [W-1:0] ptr_q   [N];
   logic [W-1:0] ptr_d   [N];

   logic [W-1:0] dir_a   [N];
   logic [N-1:0] elig;
   logic [N-1:0] arb_req [N];
   logic [N-1:0] arb_gnt [N];
   logic [W-1:0] arb_idx [N];
   logic [N-1:0] arb_any;

   for (genvar g = 0; g < N; g++) begin : g_port
      assign dir_a[g]            = req_dir[g*W +: W];
      assign out_sel[g*W +: W]   = owner_q[g];

      rr_arbiter #(.N(N), .W(W)) u_arb (
         .req     (arb_req[g]),
         .ptr     (ptr_q[g]),
         .gnt     (arb_gnt[g]),
         .gnt_idx (arb_idx[g]),
         .gnt_any (arb_any[g])
      );
   end

   // Holders and out-of-range directions never compete; busy outputs do not arbitrate.
   always_comb begin
      elig = '0;
      for (int i = 0; i < N; i++) begin
         elig[i] = req_valid[i] && !grant_q[i] && (int'(dir_a[i]) < N);
      end
      for (int o = 0; o < N; o++) begin
         arb_req[o] = '0;
         for (int i = 0; i < N; i++) begin
            arb_req[o][i] = elig[i] && (int'(dir_a[i]) == o) && !busy_q[o];
         end
      end
   end

   always_comb begin
      busy_d  = busy_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      for (int o = 0; o < N; o++) begin
         if (busy_q[o] && relieve[owner_q[o]]) begin
            busy_d[o]             = 1'b0;
            grant_d[owner_q[o]]   = 1'b0;
         end else if (arb_any[o]) begin
            busy_d[o]  = 1'b1;
            owner_d[o] = arb_idx[o];
            ptr_d[o]   = W'((int'(arb_idx[o]) + 1) % N);
            grant_d    = grant_d | arb_gnt[o];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         grant_q <= '0;
         for (int o = 0; o < N; o++) begin
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
         end
      end else begin
         busy_q  <= busy_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_status = grant_q;
   assign out_busy     = busy_q;

endmodule

// File: tb/tb_switch_route_arbiter.sv
// Directed bench for switch_route_arbiter: default N=4 build plus a 3-bit
// direction build for out-of-range direction requests.
module tb_switch_route_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid, relieve, grant_status, out_busy;
   logic [7:0]  req_dir, out_sel;

   logic [3:0]  w3_req_valid, w3_relieve, w3_grant_status, w3_out_busy;
   logic [11:0] w3_req_dir, w3_out_sel;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   switch_route_arbiter #(.N(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_dir      (req_dir),
      .relieve      (relieve),
      .grant_status (grant_status),
      .out_busy     (out_busy),
      .out_sel      (out_sel)
   );

   switch_route_arbiter #(.N(4), .REQUEST_WIDTH(3)) dut_w3 (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (w3_req_valid),
      .req_dir      (w3_req_dir),
      .relieve      (w3_relieve),
      .grant_status (w3_grant_status),
      .out_busy     (w3_out_busy),
      .out_sel      (w3_out_sel)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_dir(input int i, input int d);
      req_dir[i*2 +: 2] = 2'(d);
   endtask

   task automatic check_state(input string tag, input logic [3:0] gs,
                              input logic [3:0] busy, input logic [7:0] sel);
      check({tag, "_gs"},   32'(grant_status), 32'(gs));
      check({tag, "_busy"}, 32'(out_busy),     32'(busy));
      check({tag, "_sel"},  32'(out_sel),      32'(sel));
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; req_dir = '0; relieve = '0;
      w3_req_valid = '0; w3_req_dir = '0; w3_relieve = '0;
      step(); step();
      rst = 1'b0;
      check_state("reset", 4'b0000, 4'b0000, 8'h00);
      check("reset_w3_gs", 32'(w3_grant_status), 32'h0);

      // 1: single request, input 0 -> East
      req_valid = 4'b0001; set_dir(0, 3);
      step();
      check_state("t1_grant", 4'b0001, 4'b1000, 8'h00);
      req_valid = '0;
      step(); step();
      check_state("t1_hold", 4'b0001, 4'b1000, 8'h00);
      relieve = 4'b0001;
      step();
      relieve = '0;
      check_state("t1_release", 4'b0000, 4'b0000, 8'h00);

      // 2: inputs 0,1,2 contend for South; expect owners 0,1,2,0
      req_valid = 4'b0111; set_dir(0, 1); set_dir(1, 1); set_dir(2, 1);
      step();
      check_state("t2_own0", 4'b0001, 4'b0010, 8'h00);
      step(); step(); step();
      check_state("t2_hold0", 4'b0001, 4'b0010, 8'h00);
      relieve = 4'b0001;
      step();
      relieve = '0;
      check_state("t2_idle0", 4'b0000, 4'b0000, 8'h00);
      step();
      check_state("t2_own1", 4'b0010, 4'b0010, 8'h04);
      step(); step(); step();
      relieve = 4'b0010;
      step();
      relieve = '0;
      check_state("t2_idle1", 4'b0000, 4'b0000, 8'h04);
      step();
      check_state("t2_own2", 4'b0100, 4'b0010, 8'h08);
      step(); step(); step();
      relieve = 4'b0100;
      step();
      relieve = '0;
      check_state("t2_idle2", 4'b0000, 4'b0000, 8'h08);
      step();
      check_state("t2_wrap0", 4'b0001, 4'b0010, 8'h00);
      relieve = 4'b0001; req_valid = '0;
      step();
      relieve = '0;
      check_state("t2_done", 4'b0000, 4'b0000, 8'h00);

      // 3: relieve by input 2 and new request by input 3 on North in one cycle
      req_valid = 4'b0100; set_dir(2, 0);
      step();
      check_state("t3_own2", 4'b0100, 4'b0001, 8'h02);
      req_valid = 4'b1000; set_dir(3, 0); relieve = 4'b0100;
      step();
      relieve = '0;
      check_state("t3_gap", 4'b0000, 4'b0000, 8'h02);
      step();
      check_state("t3_own3", 4'b1000, 4'b0001, 8'h03);
      relieve = 4'b0001;
      step();
      check_state("t3_nonowner", 4'b1000, 4'b0001, 8'h03);
      relieve = 4'b1000; req_valid = '0;
      step();
      relieve = '0;
      check_state("t3_done", 4'b0000, 4'b0000, 8'h03);

      // 4: 3-bit build, input 1 asks for direction 5 while input 0 asks West
      w3_req_valid = 4'b0011;
      w3_req_dir[2:0] = 3'd2;
      w3_req_dir[5:3] = 3'd5;
      step();
      check("t4_gs",   32'(w3_grant_status), 32'h1);
      check("t4_busy", 32'(w3_out_busy),     32'h4);
      check("t4_sel",  32'(w3_out_sel),      32'h0);
      step(); step(); step();
      check("t4_gs_later",   32'(w3_grant_status), 32'h1);
      check("t4_busy_later", 32'(w3_out_busy),     32'h4);
      w3_req_valid = '0;

      // 5: four inputs to four distinct outputs
      req_valid = 4'b1111;
      set_dir(0, 1); set_dir(1, 2); set_dir(2, 3); set_dir(3, 0);
      step();
      check_state("t5_all", 4'b1111, 4'b1111, 8'h93);

      // 6: reset while holding, then pointer restarts at 0
      req_valid = '0; rst = 1'b1;
      step();
      rst = 1'b0;
      check_state("t6_reset", 4'b0000, 4'b0000, 8'h00);
      check("t6_w3_gs", 32'(w3_grant_status), 32'h0);
      req_valid = 4'b1010; set_dir(1, 2); set_dir(3, 2);
      step();
      check_state("t6_regrant", 4'b0010, 4'b0100, 8'h10);
      step();
      check_state("t6_wait3", 4'b0010, 4'b0100, 8'h10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
